// File: rtl/clint_pkg.sv
// Shared definitions for the core-local interrupt controller: register
// offsets, FSM state and decode encodings, and the byte-merge helper.
package clint_pkg;

  localparam logic [31:0] CLINT_MSIP_OFF     = 32'h0000_0000;
  localparam logic [31:0] CLINT_MTIMECMP_OFF = 32'h0000_4000;
  localparam logic [31:0] CLINT_MTIME_OFF    = 32'h0000_BFF8;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } clint_state_t;

  typedef enum logic [1:0] {
    REG_MSIP     = 2'd0,
    REG_MTIMECMP = 2'd1,
    REG_MTIME    = 2'd2,
    REG_NONE     = 2'd3
  } clint_reg_t;

  // Replace each byte of old whose strobe is set with the matching byte of wdata.
  function automatic logic [63:0] clint_merge(input logic [63:0] old_val,
                                              input logic [63:0] wdata,
                                              input logic [7:0]  strb);
    logic [63:0] res;
    res = old_val;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_sync2.sv
// Two-flop synchroniser for a single asynchronous level input; clears to 0
// on reset. Adds exactly two cycles of latency on each edge.
module clint_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Shift the raw input through two flops to settle metastability.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/clint.sv
// Core-local interrupt controller: MSIP / MTIMECMP / MTIME registers behind a
// single-outstanding MMIO port, plus the timer, software and external
// interrupt levels fed to the CSR unit.
module clint
  import clint_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          TICK_DIV  = 1,
  parameter int          ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic [7:0]        req_strb,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       resp_rdata,
  output logic              resp_err,
  input  logic              ext_irq,
  output logic              trint,
  output logic              swint,
  output logic              exint,
  output logic [63:0]       mtime_o
);

  // A one-bit prescaler is kept even when TICK_DIV is 1 so the logic is uniform.
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  clint_state_t r_state;
  logic         r_req_ready;
  logic         r_resp_valid;
  logic [63:0]  r_resp_rdata;
  logic         r_resp_err;

  logic         r_msip;
  logic [63:0]  r_mtime;
  logic [63:0]  r_mtimecmp;
  logic [PW-1:0] r_presc;
  logic         r_trint;
  logic         r_swint;

  logic              w_accept;
  logic [ADDR_W-1:0] w_offset;
  clint_reg_t        w_sel;
  logic [63:0]       w_rd_value;
  logic              w_wr_msip;
  logic              w_wr_mtimecmp;
  logic              w_wr_mtime;
  logic              w_tick;
  logic [PW-1:0]     w_presc_next;
  logic              w_msip_next;
  logic [63:0]       w_mtime_next;
  logic [63:0]       w_mtimecmp_next;

  assign w_accept = (r_state == IDLE) && req_valid;
  assign w_offset = req_addr - ADDR_W'(BASE_ADDR);

  // Decode the window offset and select the pre-update value for loads.
  always_comb begin
    w_sel      = REG_NONE;
    w_rd_value = 64'd0;
    if (w_offset == ADDR_W'(CLINT_MSIP_OFF)) begin
      w_sel      = REG_MSIP;
      w_rd_value = {63'd0, r_msip};
    end else if (w_offset == ADDR_W'(CLINT_MTIMECMP_OFF)) begin
      w_sel      = REG_MTIMECMP;
      w_rd_value = r_mtimecmp;
    end else if (w_offset == ADDR_W'(CLINT_MTIME_OFF)) begin
      w_sel      = REG_MTIME;
      w_rd_value = r_mtime;
    end
  end

  assign w_wr_msip     = w_accept && req_write && (w_sel == REG_MSIP);
  assign w_wr_mtimecmp = w_accept && req_write && (w_sel == REG_MTIMECMP);
  assign w_wr_mtime    = w_accept && req_write && (w_sel == REG_MTIME);

  // The prescaler wraps at TICK_DIV-1; that wrap is the mtime tick. An mtime
  // store restarts the prescaler and overrides any tick in the same cycle.
  assign w_tick       = (r_presc == PW'(TICK_DIV - 1));
  assign w_presc_next = (w_wr_mtime || w_tick) ? '0 : r_presc + PW'(1);

  assign w_msip_next     = (w_wr_msip && req_strb[0]) ? req_wdata[0] : r_msip;
  assign w_mtimecmp_next = w_wr_mtimecmp ? clint_merge(r_mtimecmp, req_wdata, req_strb)
                                         : r_mtimecmp;
  assign w_mtime_next    = w_wr_mtime ? clint_merge(r_mtime, req_wdata, req_strb)
                         : (w_tick ? r_mtime + 64'd1 : r_mtime);

  // Request/response handshake FSM with registered port outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 64'd0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_state      <= RESP;
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= req_write ? 64'd0 : w_rd_value;
            r_resp_err   <= (w_sel == REG_NONE);
          end
        end
        RESP: begin
          if (resp_ready) begin
            r_state      <= IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 64'd0;
            r_resp_err   <= 1'b0;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
        end
      endcase
    end
  end

  // Timer/soft-interrupt state and the registered interrupt levels, which are
  // computed from post-update values so they never lag the registers by more
  // than one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_msip     <= 1'b0;
      r_mtime    <= 64'd0;
      r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      r_presc    <= '0;
      r_trint    <= 1'b0;
      r_swint    <= 1'b0;
    end else begin
      r_msip     <= w_msip_next;
      r_mtime    <= w_mtime_next;
      r_mtimecmp <= w_mtimecmp_next;
      r_presc    <= w_presc_next;
      r_trint    <= (w_mtime_next >= w_mtimecmp_next);
      r_swint    <= w_msip_next;
    end
  end

  clint_sync2 u_ext_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (ext_irq),
    .o_q   (exint)
  );

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign trint      = r_trint;
  assign swint      = r_swint;
  assign mtime_o    = r_mtime;

endmodule

// File: tb/tb_clint.sv
// Directed bench for clint. Two instances share one request bus: "a" ticks
// every cycle, "b" ticks every fourth cycle; both handshake in lock-step.
module tb_clint;

  localparam logic [31:0] BASE   = 32'h0200_0000;
  localparam logic [31:0] A_MSIP = BASE + 32'h0000_0000;
  localparam logic [31:0] A_CMP  = BASE + 32'h0000_4000;
  localparam logic [31:0] A_TIME = BASE + 32'h0000_BFF8;
  localparam logic [31:0] A_BAD  = BASE + 32'h0000_0100;
  localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_write;
  logic [7:0]  req_strb;
  logic [63:0] req_wdata;
  logic        resp_ready;
  logic        ext_irq;

  logic        req_ready_a, resp_valid_a, resp_err_a, trint_a, swint_a, exint_a;
  logic [63:0] resp_rdata_a, mtime_a;
  logic        req_ready_b, resp_valid_b, resp_err_b, trint_b, swint_b, exint_b;
  logic [63:0] resp_rdata_b, mtime_b;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] rd_a, rd_b, t0_a, t0_b;
  logic        er_a;

  always #5 clk = ~clk;

  clint #(.BASE_ADDR(BASE), .TICK_DIV(1), .ADDR_W(32)) u_dut_a (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready_a), .req_addr(req_addr),
    .req_write(req_write), .req_strb(req_strb), .req_wdata(req_wdata),
    .resp_valid(resp_valid_a), .resp_ready(resp_ready), .resp_rdata(resp_rdata_a),
    .resp_err(resp_err_a), .ext_irq(ext_irq), .trint(trint_a), .swint(swint_a),
    .exint(exint_a), .mtime_o(mtime_a)
  );

  clint #(.BASE_ADDR(BASE), .TICK_DIV(4), .ADDR_W(32)) u_dut_b (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready_b), .req_addr(req_addr),
    .req_write(req_write), .req_strb(req_strb), .req_wdata(req_wdata),
    .resp_valid(resp_valid_b), .resp_ready(resp_ready), .resp_rdata(resp_rdata_b),
    .resp_err(resp_err_b), .ext_irq(ext_irq), .trint(trint_b), .swint(swint_b),
    .exint(exint_b), .mtime_o(mtime_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance n clock edges, ending 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue one request; returns in the first response cycle.
  task automatic start_req(input string tag, input logic [31:0] addr, input logic wr,
                           input logic [63:0] wd, input logic [7:0] strb);
    check({tag, "_rdy"}, 64'({req_ready_b, req_ready_a}), 64'd3);
    req_valid = 1'b1;
    req_addr  = addr;
    req_write = wr;
    req_wdata = wd;
    req_strb  = strb;
    tick(1);
    req_valid = 1'b0;
    req_write = 1'b0;
    req_strb  = 8'h00;
    check({tag, "_vld"}, 64'({resp_valid_b, resp_valid_a}), 64'd3);
    rd_a = resp_rdata_a;
    rd_b = resp_rdata_b;
    er_a = resp_err_a;
    $display("xfer %s addr=%h wr=%0b wdata=%h rdata_a=%h rdata_b=%h err=%0b",
             tag, addr, wr, wd, rd_a, rd_b, er_a);
  endtask

  task automatic finish_resp();
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = 32'd0; req_write = 1'b0;
    req_strb = 8'h00; req_wdata = 64'd0; resp_ready = 1'b1; ext_irq = 1'b0;
    rd_a = 64'd0; rd_b = 64'd0; t0_a = 64'd0; t0_b = 64'd0; er_a = 1'b0;

    // Reset state
    #20;
    check("rst_req_ready", 64'({req_ready_b, req_ready_a}), 64'd3);
    check("rst_resp_valid", 64'({resp_valid_b, resp_valid_a}), 64'd0);
    check("rst_mtime_a", mtime_a, 64'd0);
    check("rst_irqs", 64'({trint_a, swint_a, exint_a, trint_b, swint_b, exint_b}), 64'd0);
    #2 reset = 1'b0;

    // Idle 10 cycles
    tick(10);
    check("idle_mtime_a", mtime_a, 64'd10);
    check("idle_mtime_b", mtime_b, 64'd2);
    check("idle_irqs", 64'({trint_a, swint_a, exint_a}), 64'd0);

    // Timer compare crossing
    start_req("cmp20", A_CMP, 1'b1, 64'd20, 8'hFF);
    check("cmp20_rdata", rd_a, 64'd0);
    check("cmp20_err", 64'(er_a), 64'd0);
    finish_resp();
    for (int i = 0; i < 100 && mtime_a != 64'd19; i++) tick(1);
    check("reach19", mtime_a, 64'd19);
    check("trint_before", 64'(trint_a), 64'd0);
    tick(1);
    check("mtime20", mtime_a, 64'd20);
    check("trint_rise", 64'(trint_a), 64'd1);
    check("trint_b_low", 64'(trint_b), 64'd0);
    start_req("cmp1000", A_CMP, 1'b1, 64'd1000, 8'hFF);
    check("trint_fall", 64'(trint_a), 64'd0);
    finish_resp();
    start_req("cmp_byte", A_CMP, 1'b1, 64'h0000_0000_0000_00AB, 8'h01);
    finish_resp();
    start_req("cmp_rd", A_CMP, 1'b0, 64'd0, 8'h00);
    check("cmp_merge", rd_a, 64'h3AB);
    finish_resp();

    // Software interrupt
    start_req("msip3", A_MSIP, 1'b1, 64'h3, 8'hFF);
    check("swint_set", 64'({swint_b, swint_a}), 64'd3);
    finish_resp();
    start_req("msip_rd", A_MSIP, 1'b0, 64'd0, 8'h00);
    check("msip_rdata", rd_a, 64'h1);
    finish_resp();
    start_req("msip0", A_MSIP, 1'b1, 64'h0, 8'hFF);
    check("swint_clr", 64'({swint_b, swint_a}), 64'd0);
    finish_resp();

    // mtime rate and read-before-tick sampling
    start_req("time_rd0", A_TIME, 1'b0, 64'd0, 8'h00);
    t0_a = rd_a;
    t0_b = rd_b;
    check("rd_pre_tick", mtime_a, t0_a + 64'd1);
    finish_resp();
    tick(6);
    start_req("time_rd1", A_TIME, 1'b0, 64'd0, 8'h00);
    check("rate_a", rd_a - t0_a, 64'd8);
    check("rate_b", rd_b - t0_b, 64'd2);
    finish_resp();

    // mtime wrap
    start_req("time_ones", A_TIME, 1'b1, ONES, 8'hFF);
    check("ones_a", mtime_a, ONES);
    check("ones_b", mtime_b, ONES);
    check("trint_ones", 64'(trint_a), 64'd1);
    finish_resp();
    check("wrap_a", mtime_a, 64'd0);
    check("trint_wrap", 64'(trint_a), 64'd0);
    tick(2);
    check("hold_b", mtime_b, ONES);
    tick(1);
    check("wrap_b", mtime_b, 64'd0);

    // Unmapped offset
    start_req("bad_rd", A_BAD, 1'b0, 64'd0, 8'h00);
    check("bad_err", 64'(er_a), 64'd1);
    check("bad_rdata", rd_a, 64'd0);
    finish_resp();

    // Response back-pressure
    resp_ready = 1'b0;
    start_req("stall_rd", A_CMP, 1'b0, 64'd0, 8'h00);
    check("stall_rdata0", rd_a, 64'h3AB);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("stall_valid", 64'(resp_valid_a), 64'd1);
      check("stall_rdata", resp_rdata_a, 64'h3AB);
      check("stall_ready", 64'(req_ready_a), 64'd0);
    end
    resp_ready = 1'b1;
    tick(1);
    check("stall_done", 64'({req_ready_a, resp_valid_a}), 64'h2);

    // External interrupt synchroniser
    ext_irq = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      check("exint", 64'(exint_a), 64'((i >= 2) && (i <= 6)));
      if (i == 5) ext_irq = 1'b0;
    end

    // Reset during a pending response
    start_req("rst_rd", A_CMP, 1'b0, 64'd0, 8'h00);
    #1 reset = 1'b1;
    #1;
    check("rst_resp_drop", 64'(resp_valid_a), 64'd0);
    check("rst_ready", 64'(req_ready_a), 64'd1);
    check("rst_mtime", mtime_a, 64'd0);
    #1 reset = 1'b0;
    tick(1);
    start_req("cmp_after_rst", A_CMP, 1'b0, 64'd0, 8'h00);
    check("cmp_reset_val", rd_a, ONES);
    finish_resp();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
